// File: rtl/synth_pkg.sv
// Shared constants for the synth voice path: note width, allocator FSM
// encodings and a helper for sizing voice index fields.
package synth_pkg;

   localparam int unsigned NOTE_W = 5;

   localparam int unsigned ST_W   = 2;
   localparam logic [1:0]  IDLE   = 2'd0;
   localparam logic [1:0]  LOOKUP = 2'd1;
   localparam logic [1:0]  COMMIT = 2'd2;

   // Bits needed to index n voices; never less than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/voice_pick.sv
// Combinational voice search: note match, lowest free voice, oldest active voice.
module voice_pick
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned NOTE_W     = synth_pkg::NOTE_W,
   parameter int unsigned AGE_W      = 3,
   parameter int unsigned IDX_W      = synth_pkg::idx_w(NUM_VOICES)
) (
   input  logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   input  logic [NUM_VOICES-1:0]        voice_active,
   input  logic [NUM_VOICES*AGE_W-1:0]  ages,
   input  logic [NOTE_W-1:0]            note,
   output logic                         match_hit,
   output logic [IDX_W-1:0]             match_idx,
   output logic                         free_hit,
   output logic [IDX_W-1:0]             free_idx,
   output logic [IDX_W-1:0]             oldest_idx
);

   logic             old_found;
   logic [AGE_W-1:0] old_age;

   // First match / first free win; oldest uses strict > so ties keep the lowest index.
   always_comb begin
      match_hit  = 1'b0;
      match_idx  = '0;
      free_hit   = 1'b0;
      free_idx   = '0;
      oldest_idx = '0;
      old_found  = 1'b0;
      old_age    = '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
         if (voice_active[i] && !match_hit &&
             voice_note[i*NOTE_W +: NOTE_W] == note) begin
            match_hit = 1'b1;
            match_idx = IDX_W'(i);
         end
         if (!voice_active[i] && !free_hit) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (voice_active[i] &&
             (!old_found || ages[i*AGE_W +: AGE_W] > old_age)) begin
            old_found  = 1'b1;
            old_age    = ages[i*AGE_W +: AGE_W];
            oldest_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: maps key make/break events onto a bank of voices,
// stealing the least recently used voice when all are busy.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned NOTE_W     = synth_pkg::NOTE_W,
   parameter int unsigned AGE_W      = 3
) (
   input  logic                         CLOCK_50,
   input  logic                         resetn,
   input  logic                         key_valid,
   input  logic                         key_make,
   input  logic [NOTE_W-1:0]            key_note,
   output logic                         key_ready,
   input  logic                         all_off,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_active,
   output logic [NUM_VOICES-1:0]        voice_trig,
   output logic                         steal
);

   localparam int unsigned IDX_W = synth_pkg::idx_w(NUM_VOICES);

   logic [ST_W-1:0]             state_q, state_d;
   logic                        ev_make_q, ev_make_d;
   logic [NOTE_W-1:0]           ev_note_q, ev_note_d;
   logic                        match_hit_q, match_hit_d;
   logic [IDX_W-1:0]            match_idx_q, match_idx_d;
   logic                        free_hit_q, free_hit_d;
   logic [IDX_W-1:0]            free_idx_q, free_idx_d;
   logic [IDX_W-1:0]            oldest_idx_q, oldest_idx_d;
   logic [NUM_VOICES*NOTE_W-1:0] notes_d;
   logic [NUM_VOICES-1:0]       active_d;
   logic [NUM_VOICES*AGE_W-1:0] ages_q, ages_d;
   logic [NUM_VOICES-1:0]       trig_d;
   logic                        steal_d;

   logic                        pk_match_hit, pk_free_hit;
   logic [IDX_W-1:0]            pk_match_idx, pk_free_idx, pk_oldest_idx;
   logic [IDX_W-1:0]            tgt;
   logic [AGE_W-1:0]            tgt_age;

   voice_pick #(
      .NUM_VOICES (NUM_VOICES),
      .NOTE_W     (NOTE_W),
      .AGE_W      (AGE_W),
      .IDX_W      (IDX_W)
   ) u_pick (
      .voice_note   (voice_note),
      .voice_active (voice_active),
      .ages         (ages_q),
      .note         (ev_note_q),
      .match_hit    (pk_match_hit),
      .match_idx    (pk_match_idx),
      .free_hit     (pk_free_hit),
      .free_idx     (pk_free_idx),
      .oldest_idx   (pk_oldest_idx)
   );

   // Events are only taken while idle and no panic is pending.
   assign key_ready = (state_q == IDLE) && !all_off;

   // Next-state and datapath update; all_off overrides every state.
   always_comb begin
      state_d      = state_q;
      ev_make_d    = ev_make_q;
      ev_note_d    = ev_note_q;
      match_hit_d  = match_hit_q;
      match_idx_d  = match_idx_q;
      free_hit_d   = free_hit_q;
      free_idx_d   = free_idx_q;
      oldest_idx_d = oldest_idx_q;
      notes_d      = voice_note;
      active_d     = voice_active;
      ages_d       = ages_q;
      trig_d       = '0;
      steal_d      = 1'b0;
      tgt          = '0;
      tgt_age      = '0;
      if (all_off) begin
         active_d = '0;
         ages_d   = '0;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (key_valid) begin
                  ev_make_d = key_make;
                  ev_note_d = key_note;
                  state_d   = LOOKUP;
               end
            end
            LOOKUP: begin
               match_hit_d  = pk_match_hit;
               match_idx_d  = pk_match_idx;
               free_hit_d   = pk_free_hit;
               free_idx_d   = pk_free_idx;
               oldest_idx_d = pk_oldest_idx;
               state_d      = COMMIT;
            end
            COMMIT: begin
               state_d = IDLE;
               if (ev_make_q) begin
                  // Retrigger keeps relative order above the target; new or stolen voices age everyone.
                  if (match_hit_q) begin
                     tgt = match_idx_q;
                     for (int i = 0; i < int'(NUM_VOICES); i++)
                        if (IDX_W'(i) == match_idx_q)
                           tgt_age = ages_q[i*AGE_W +: AGE_W];
                  end else if (free_hit_q) begin
                     tgt     = free_idx_q;
                     tgt_age = '1;
                  end else begin
                     tgt     = oldest_idx_q;
                     tgt_age = '1;
                     steal_d = 1'b1;
                  end
                  for (int i = 0; i < int'(NUM_VOICES); i++) begin
                     if (IDX_W'(i) == tgt) begin
                        ages_d[i*AGE_W +: AGE_W] = '0;
                        trig_d[i]                = 1'b1;
                        if (!match_hit_q) begin
                           notes_d[i*NOTE_W +: NOTE_W] = ev_note_q;
                           active_d[i]                 = 1'b1;
                        end
                     end else if (voice_active[i] &&
                                  ages_q[i*AGE_W +: AGE_W] < tgt_age) begin
                        ages_d[i*AGE_W +: AGE_W] = ages_q[i*AGE_W +: AGE_W] + AGE_W'(1);
                     end
                  end
               end else if (match_hit_q) begin
                  for (int i = 0; i < int'(NUM_VOICES); i++) begin
                     if (IDX_W'(i) == match_idx_q) begin
                        active_d[i]              = 1'b0;
                        ages_d[i*AGE_W +: AGE_W] = '0;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, event latch, lookup results, voice registers and pulses.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q      <= IDLE;
         ev_make_q    <= 1'b0;
         ev_note_q    <= '0;
         match_hit_q  <= 1'b0;
         match_idx_q  <= '0;
         free_hit_q   <= 1'b0;
         free_idx_q   <= '0;
         oldest_idx_q <= '0;
         voice_note   <= '0;
         voice_active <= '0;
         ages_q       <= '0;
         voice_trig   <= '0;
         steal        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ev_make_q    <= ev_make_d;
         ev_note_q    <= ev_note_d;
         match_hit_q  <= match_hit_d;
         match_idx_q  <= match_idx_d;
         free_hit_q   <= free_hit_d;
         free_idx_q   <= free_idx_d;
         oldest_idx_q <= oldest_idx_d;
         voice_note   <= notes_d;
         voice_active <= active_d;
         ages_q       <= ages_d;
         voice_trig   <= trig_d;
         steal        <= steal_d;
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a timestamp-based LRU model predicts
// each event's outcome, which is popped and compared at the output cycle.
module tb_voice_allocator;

   localparam int unsigned NV = 4;
   localparam int unsigned NW = 5;
   localparam int unsigned AW = 3;

   logic              CLOCK_50 = 1'b0;
   logic              resetn;
   logic              key_valid;
   logic              key_make;
   logic [NW-1:0]     key_note;
   logic              key_ready;
   logic              all_off;
   logic [NV*NW-1:0]  voice_note;
   logic [NV-1:0]     voice_active;
   logic [NV-1:0]     voice_trig;
   logic              steal;

   always #5 CLOCK_50 = ~CLOCK_50;

   voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .AGE_W(AW)) dut (
      .CLOCK_50     (CLOCK_50),
      .resetn       (resetn),
      .key_valid    (key_valid),
      .key_make     (key_make),
      .key_note     (key_note),
      .key_ready    (key_ready),
      .all_off      (all_off),
      .voice_note   (voice_note),
      .voice_active (voice_active),
      .voice_trig   (voice_trig),
      .steal        (steal)
   );

   typedef struct {
      logic [NV-1:0]    trig;
      logic             stl;
      logic [NV*NW-1:0] notes;
      logic [NV-1:0]    act;
   } exp_t;

   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   // Reference model: last-use timestamps instead of age counters.
   logic [NW-1:0] m_note [NV];
   logic          m_act  [NV];
   int            m_ts   [NV];
   int            stamp = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [NV*NW-1:0] m_notes();
      logic [NV*NW-1:0] v;
      for (int i = 0; i < int'(NV); i++) v[i*NW +: NW] = m_note[i];
      return v;
   endfunction

   function automatic logic [NV-1:0] m_acts();
      logic [NV-1:0] v;
      for (int i = 0; i < int'(NV); i++) v[i] = m_act[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(NV); i++) begin
         m_note[i] = '0;
         m_act[i]  = 1'b0;
         m_ts[i]   = 0;
      end
   endtask

   task automatic model_all_off();
      for (int i = 0; i < int'(NV); i++) m_act[i] = 1'b0;
   endtask

   // Predict one event and push the expected output snapshot.
   task automatic model_event(input logic mk, input logic [NW-1:0] n);
      exp_t e;
      int   hit, fr, old;
      hit = -1; fr = -1; old = -1;
      e.trig = '0;
      e.stl  = 1'b0;
      for (int i = 0; i < int'(NV); i++) begin
         if (hit < 0 && m_act[i] && m_note[i] == n) hit = i;
         if (fr < 0 && !m_act[i]) fr = i;
         if (m_act[i] && (old < 0 || m_ts[i] < m_ts[old])) old = i;
      end
      if (mk) begin
         stamp++;
         if (hit >= 0) begin
            e.trig[hit] = 1'b1;
            m_ts[hit]   = stamp;
         end else begin
            if (fr < 0) begin
               fr    = old;
               e.stl = 1'b1;
            end
            e.trig[fr] = 1'b1;
            m_note[fr] = n;
            m_act[fr]  = 1'b1;
            m_ts[fr]   = stamp;
         end
      end else if (hit >= 0) begin
         m_act[hit] = 1'b0;
      end
      e.notes = m_notes();
      e.act   = m_acts();
      sb.push_back(e);
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!key_ready && w < 20) begin
         @(negedge CLOCK_50);
         w++;
      end
      check("ready_wait", 32'(key_ready), 32'd1);
   endtask

   // Drive one event, check busy/latency, then compare at the output cycle.
   task automatic send(input logic mk, input logic [NW-1:0] n);
      exp_t e;
      wait_ready();
      key_valid = 1'b1;
      key_make  = mk;
      key_note  = n;
      model_event(mk, n);
      @(negedge CLOCK_50);
      key_valid = 1'b0;
      check("busy_lookup", 32'(key_ready), 32'd0);
      @(negedge CLOCK_50);
      check("busy_commit", 32'(key_ready), 32'd0);
      check("early_trig", 32'(voice_trig), 32'd0);
      @(negedge CLOCK_50);
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("trig",   32'(voice_trig),   32'(e.trig));
         check("steal",  32'(steal),        32'(e.stl));
         check("notes",  32'(voice_note),   32'(e.notes));
         check("active", 32'(voice_active), 32'(e.act));
         check("ready_back", 32'(key_ready), 32'd1);
      end
      @(negedge CLOCK_50);
      check("trig_clear",  32'(voice_trig), 32'd0);
      check("steal_clear", 32'(steal),      32'd0);
   endtask

   task automatic panic(input logic with_key);
      key_valid = with_key;
      key_make  = 1'b1;
      key_note  = 5'd7;
      all_off   = 1'b1;
      #1;
      check("ready_panic", 32'(key_ready), 32'd0);
      @(negedge CLOCK_50);
      all_off   = 1'b0;
      key_valid = 1'b0;
      model_all_off();
      repeat (3) begin
         @(negedge CLOCK_50);
         check("panic_trig", 32'(voice_trig), 32'd0);
      end
      check("panic_active", 32'(voice_active), 32'(m_acts()));
      check("panic_notes",  32'(voice_note),   32'(m_notes()));
      check("panic_ready",  32'(key_ready),    32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      resetn    = 1'b0;
      key_valid = 1'b0;
      key_make  = 1'b0;
      key_note  = '0;
      all_off   = 1'b0;
      model_reset();
      repeat (2) @(negedge CLOCK_50);
      check("rst_notes",  32'(voice_note),   32'd0);
      check("rst_active", 32'(voice_active), 32'd0);
      check("rst_trig",   32'(voice_trig),   32'd0);
      check("rst_steal",  32'(steal),        32'd0);
      resetn = 1'b1;
      @(negedge CLOCK_50);
      check("rst_ready", 32'(key_ready), 32'd1);

      // Three notes land on voices 0,1,2.
      send(1'b1, 5'd12);
      send(1'b1, 5'd14);
      send(1'b1, 5'd16);

      // Fill all four, then steal LRU twice.
      panic(1'b0);
      for (int k = 1; k <= 4; k++) send(1'b1, NW'(k));
      send(1'b1, 5'd9);
      send(1'b1, 5'd10);

      // Retrigger, release, release of an unheld note, LRU after retrigger.
      panic(1'b0);
      send(1'b1, 5'd5);
      send(1'b1, 5'd6);
      send(1'b1, 5'd12);
      send(1'b1, 5'd12);
      send(1'b0, 5'd12);
      send(1'b0, 5'd20);
      send(1'b1, 5'd12);
      send(1'b1, 5'd13);
      send(1'b1, 5'd5);
      send(1'b1, 5'd21);
      send(1'b1, 5'd0);

      // Panic coincident with a key event drops the event.
      panic(1'b1);

      // Panic while an event sits in LOOKUP.
      send(1'b1, 5'd3);
      key_valid = 1'b1;
      key_make  = 1'b1;
      key_note  = 5'd8;
      @(negedge CLOCK_50);
      key_valid = 1'b0;
      all_off   = 1'b1;
      @(negedge CLOCK_50);
      all_off = 1'b0;
      model_all_off();
      repeat (3) begin
         @(negedge CLOCK_50);
         check("lookup_off_trig", 32'(voice_trig), 32'd0);
      end
      check("lookup_off_active", 32'(voice_active), 32'(m_acts()));
      check("lookup_off_notes",  32'(voice_note),   32'(m_notes()));

      // Reset while an event sits in LOOKUP.
      send(1'b1, 5'd17);
      key_valid = 1'b1;
      key_make  = 1'b1;
      key_note  = 5'd19;
      @(negedge CLOCK_50);
      key_valid = 1'b0;
      resetn    = 1'b0;
      @(negedge CLOCK_50);
      resetn = 1'b1;
      model_reset();
      check("lookup_rst_notes",  32'(voice_note),   32'd0);
      check("lookup_rst_active", 32'(voice_active), 32'd0);
      check("lookup_rst_trig",   32'(voice_trig),   32'd0);
      check("lookup_rst_ready",  32'(key_ready),    32'd1);
      repeat (3) begin
         @(negedge CLOCK_50);
         check("lookup_rst_idle_trig", 32'(voice_trig), 32'd0);
      end
      check("lookup_rst_notes2", 32'(voice_note), 32'd0);
      send(1'b1, 5'd11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
